float_max_reduce: RTL and testbench

Streaming floating-point max/min reduction unit for the Versat datapath. It consumes one IEEE-754-style operand per cycle while the accelerator is running and tracks the running extreme (max or min) and the index of its first occurrence. It uses the same sign-magnitude ordering and NaN detection as the float comparison unit it sits beside. It is the downstream consumer of per-element comparison: it folds a vector into one value/index pair, which is read by software or fed to the next stage.

---
 rtl/float_max_reduce_if.sv | 25 ++
 rtl/float_max_reduce.sv | 169 ++++++++++++++++
 tb/tb_float_max_reduce.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/float_max_reduce_if.sv
// Handshake/config/result bundle for float_max_reduce.
// master drives the stream and config; slave is the reduction unit.
interface float_max_reduce_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic              run;
   logic              running;
   logic [DATA_W-1:0] in0;
   logic [CNT_W-1:0]  length;
   logic              mode;
   logic [DATA_W-1:0] out0;
   logic [CNT_W-1:0]  out1;
   logic              done;

   modport master (
      output run, running, in0, length, mode,
      input  out0, out1, done
   );

   modport slave (
      input  run, running, in0, length, mode,
      output out0, out1, done
   );
endinterface

// File: rtl/float_max_reduce.sv
// Streaming float max/min reduction: folds a vector into (extreme value, first index).
// Optional FLOAT_MAX_REDUCE_NAN_PROP_EN: first NaN becomes a sticky result.
//
// state  | meaning
// IDLE   | after reset, waiting for run
// ACCUM  | consuming elements while running=1
// DRAIN  | retiring the last stage-2 compare (entered directly on run with length=0)
// DONE   | result final, done=1, held until next run
module float_max_reduce #(
   parameter int DATA_W = 32,
   parameter int EXP_W  = 8,
   parameter int CNT_W  = 16
) (
   input logic               clk,
   input logic               rst,
   float_max_reduce_if.slave bus
);

   localparam int MANT_W = DATA_W - EXP_W - 1;
   localparam logic [DATA_W-1:0] CANON_NAN =
      {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   function automatic logic is_nan(input logic [DATA_W-1:0] v);
      return (&v[DATA_W-2 -: EXP_W]) && (|v[MANT_W-1:0]);
   endfunction

   // Maps sign-magnitude to an unsigned key with the same order; -0 sorts below +0.
   function automatic logic [DATA_W-1:0] order_key(input logic [DATA_W-1:0] v);
      return v[DATA_W-1] ? {1'b0, ~v[DATA_W-2:0]} : {1'b1, v[DATA_W-2:0]};
   endfunction

   logic [1:0]        state_q,      state_d;
   logic [CNT_W-1:0]  len_q,        len_d;
   logic              mode_q,       mode_d;
   logic [CNT_W-1:0]  count_q,      count_d;
   logic              s1_valid_q,   s1_valid_d;
   logic [DATA_W-1:0] s1_data_q,    s1_data_d;
   logic [CNT_W-1:0]  s1_idx_q,     s1_idx_d;
   logic              best_valid_q, best_valid_d;
   logic [DATA_W-1:0] best_q,       best_d;
   logic [CNT_W-1:0]  idx_q,        idx_d;
`ifdef FLOAT_MAX_REDUCE_NAN_PROP_EN
   logic              nan_seen_q,   nan_seen_d;
`endif

   logic [DATA_W-1:0] e_key;
   logic [DATA_W-1:0] b_key;
   logic              better;
   logic [CNT_W-1:0]  count_inc;

   always_comb begin
      e_key     = order_key(s1_data_q);
      b_key     = order_key(best_q);
      better    = mode_q ? (e_key < b_key) : (e_key > b_key);
      count_inc = count_q + 1'b1;
   end

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      mode_d       = mode_q;
      count_d      = count_q;
      s1_valid_d   = 1'b0;
      s1_data_d    = s1_data_q;
      s1_idx_d     = s1_idx_q;
      best_valid_d = best_valid_q;
      best_d       = best_q;
      idx_d        = idx_q;
`ifdef FLOAT_MAX_REDUCE_NAN_PROP_EN
      nan_seen_d   = nan_seen_q;
`endif

      // Stage 2: fold the registered element into the running best.
      if (s1_valid_q) begin
`ifdef FLOAT_MAX_REDUCE_NAN_PROP_EN
         if (!nan_seen_q) begin
            if (is_nan(s1_data_q)) begin
               nan_seen_d   = 1'b1;
               best_valid_d = 1'b1;
               best_d       = CANON_NAN;
               idx_d        = s1_idx_q;
            end else if (!best_valid_q || better) begin
               best_valid_d = 1'b1;
               best_d       = s1_data_q;
               idx_d        = s1_idx_q;
            end
         end
`else
         if (!is_nan(s1_data_q) && (!best_valid_q || better)) begin
            best_valid_d = 1'b1;
            best_d       = s1_data_q;
            idx_d        = s1_idx_q;
         end
`endif
      end

      // Stage 1 / sequencing.
      case (state_q)
         S_ACCUM: begin
            if (bus.running) begin
               s1_valid_d = 1'b1;
               s1_data_d  = bus.in0;
               s1_idx_d   = count_q;
               count_d    = count_inc;
               if (count_inc == len_q) state_d = S_DRAIN;
            end
         end
         S_DRAIN: state_d = S_DONE;
         default: ;
      endcase

      // run wins over everything, including an in-flight stage-2 update.
      if (bus.run) begin
         state_d      = (bus.length == '0) ? S_DRAIN : S_ACCUM;
         len_d        = bus.length;
         mode_d       = bus.mode;
         count_d      = '0;
         s1_valid_d   = 1'b0;
         best_valid_d = 1'b0;
         best_d       = CANON_NAN;
         idx_d        = '1;
`ifdef FLOAT_MAX_REDUCE_NAN_PROP_EN
         nan_seen_d   = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         mode_q       <= 1'b0;
         count_q      <= '0;
         s1_valid_q   <= 1'b0;
         s1_data_q    <= '0;
         s1_idx_q     <= '0;
         best_valid_q <= 1'b0;
         best_q       <= '0;
         idx_q        <= '0;
`ifdef FLOAT_MAX_REDUCE_NAN_PROP_EN
         nan_seen_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         mode_q       <= mode_d;
         count_q      <= count_d;
         s1_valid_q   <= s1_valid_d;
         s1_data_q    <= s1_data_d;
         s1_idx_q     <= s1_idx_d;
         best_valid_q <= best_valid_d;
         best_q       <= best_d;
         idx_q        <= idx_d;
`ifdef FLOAT_MAX_REDUCE_NAN_PROP_EN
         nan_seen_q   <= nan_seen_d;
`endif
      end
   end

   assign bus.out0 = best_q;
   assign bus.out1 = idx_q;
   assign bus.done = (state_q == S_DONE);

endmodule

// File: tb/tb_float_max_reduce.sv
// Directed, table-driven bench for float_max_reduce (default and NaN-propagating builds).
module tb_float_max_reduce;

   localparam logic [31:0] CANON = 32'h7FC00000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   float_max_reduce_if #(.DATA_W(32), .CNT_W(16)) bus ();

   float_max_reduce #(.DATA_W(32), .EXP_W(8), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [15:0]      len;
      logic             mode;
      logic [3:0][31:0] elems;
      int               stall_at;
      int               stall_n;
      logic [31:0]      exp0;
      logic [15:0]      exp1;
      int               exp_lat;
   } vec_t;

   int checks = 0;
   int errors = 0;
   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] len, input logic mode,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3,
                               input int stall_at, input int stall_n,
                               input logic [31:0] exp0, input logic [15:0] exp1,
                               input int exp_lat);
      vec_t v;
      v.len = len; v.mode = mode;
      v.elems[0] = e0; v.elems[1] = e1; v.elems[2] = e2; v.elems[3] = e3;
      v.stall_at = stall_at; v.stall_n = stall_n;
      v.exp0 = exp0; v.exp1 = exp1; v.exp_lat = exp_lat;
      return v;
   endfunction

   task automatic wait_done(input int id, inout int lat, input int exp_lat);
      while (!bus.done && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("vec%0d done_latency", id), 32'(lat), 32'(exp_lat));
   endtask

   task automatic run_vec(input int id, input vec_t v);
      logic [31:0] junk;
      int lat;
      junk = v.mode ? 32'hFF7FFFFF : 32'h7F7FFFFF;
      @(negedge clk);
      bus.run = 1'b1; bus.length = v.len; bus.mode = v.mode;
      bus.running = 1'b1; bus.in0 = junk;
      lat = 0;
      @(negedge clk);
      lat++;
      bus.run = 1'b0;
      check($sformatf("vec%0d start_out0", id), bus.out0, CANON);
      check($sformatf("vec%0d start_out1", id), 32'(bus.out1), 32'h0000FFFF);
      check($sformatf("vec%0d start_done", id), 32'(bus.done), 32'd0);
      for (int i = 0; i < int'(v.len); i++) begin
         if (i == v.stall_at) begin
            for (int s = 0; s < v.stall_n; s++) begin
               bus.running = 1'b0; bus.in0 = junk;
               @(negedge clk);
               lat++;
            end
         end
         bus.running = 1'b1; bus.in0 = v.elems[i];
         @(negedge clk);
         lat++;
      end
      bus.running = 1'b1; bus.in0 = junk;
      wait_done(id, lat, v.exp_lat);
      check($sformatf("vec%0d out0", id), bus.out0, v.exp0);
      check($sformatf("vec%0d out1", id), 32'(bus.out1), 32'(v.exp1));
   endtask

   initial begin
      int lat;
      bus.run = 1'b0; bus.running = 1'b0; bus.in0 = '0; bus.length = '0; bus.mode = 1'b0;

      vecs[0] = mk(4, 0, 32'h3F800000, 32'hC0000000, 32'h40600000, 32'h3F000000, 99, 0, 32'h40600000, 2, 6);
      vecs[1] = mk(4, 1, 32'h3F800000, 32'hC0000000, 32'h40600000, 32'h3F000000, 2, 2, 32'hC0000000, 1, 8);
      vecs[2] = mk(3, 0, 32'h00000000, 32'h80000000, 32'h00000000, 0, 99, 0, 32'h00000000, 0, 5);
      vecs[3] = mk(3, 1, 32'h00000000, 32'h80000000, 32'h00000000, 0, 99, 0, 32'h80000000, 1, 5);
`ifdef FLOAT_MAX_REDUCE_NAN_PROP_EN
      vecs[4] = mk(3, 0, 32'h3F800000, 32'h7FC00001, 32'h40000000, 0, 99, 0, CANON, 1, 5);
      vecs[6] = mk(3, 0, 32'h7F800001, 32'hFFC00000, 32'h7FFFFFFF, 0, 99, 0, CANON, 0, 5);
`else
      vecs[4] = mk(3, 0, 32'h3F800000, 32'h7FC00001, 32'h40000000, 0, 99, 0, 32'h40000000, 2, 5);
      vecs[6] = mk(3, 0, 32'h7F800001, 32'hFFC00000, 32'h7FFFFFFF, 0, 99, 0, CANON, 16'hFFFF, 5);
`endif
      vecs[5]  = mk(0, 0, 0, 0, 0, 0, 99, 0, CANON, 16'hFFFF, 2);
      vecs[7]  = mk(3, 0, 32'hFF800000, 32'h7F800000, 32'h7F7FFFFF, 0, 99, 0, 32'h7F800000, 1, 5);
      vecs[8]  = mk(3, 1, 32'h3F800000, 32'hFF800000, 32'hFF800000, 0, 99, 0, 32'hFF800000, 1, 5);
      vecs[9]  = mk(3, 1, 32'hC0000000, 32'hC0400000, 32'hBF800000, 0, 99, 0, 32'hC0400000, 1, 5);
      vecs[10] = mk(3, 0, 32'hC0000000, 32'hC0400000, 32'hBF800000, 0, 1, 3, 32'hBF800000, 2, 8);

      repeat (3) @(negedge clk);
      check("reset out0", bus.out0, 32'h0);
      check("reset out1", 32'(bus.out1), 32'h0);
      check("reset done", 32'(bus.done), 32'h0);
      rst = 1'b1;
      @(negedge clk);
      check("idle done", 32'(bus.done), 32'h0);

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

      // Abort mid-ACCUM while 64.0 sits in stage 1; only the new two elements count.
      @(negedge clk);
      bus.run = 1'b1; bus.length = 16'd4; bus.mode = 1'b0; bus.running = 1'b1; bus.in0 = 32'h7F7FFFFF;
      @(negedge clk);
      bus.run = 1'b0; bus.in0 = 32'h42000000;
      @(negedge clk);
      bus.in0 = 32'h42800000;
      @(negedge clk);
      bus.run = 1'b1; bus.length = 16'd2; bus.in0 = 32'h7F7FFFFF;
      lat = 0;
      @(negedge clk);
      lat++;
      bus.run = 1'b0;
      check("abort cleared out0", bus.out0, CANON);
      check("abort cleared out1", 32'(bus.out1), 32'h0000FFFF);
      bus.in0 = 32'h3F800000;
      @(negedge clk);
      lat++;
      bus.in0 = 32'h3F000000;
      @(negedge clk);
      lat++;
      bus.in0 = 32'h7F7FFFFF;
      wait_done(100, lat, 4);
      check("abort out0", bus.out0, 32'h3F800000);
      check("abort out1", 32'(bus.out1), 32'h0);

      // Asynchronous reset mid-stream, checked between clock edges.
      @(negedge clk);
      bus.run = 1'b1; bus.length = 16'd4; bus.mode = 1'b0; bus.running = 1'b1; bus.in0 = 32'h0;
      @(negedge clk);
      bus.run = 1'b0; bus.in0 = 32'h3F800000;
      @(negedge clk);
      bus.in0 = 32'h40000000;
      @(negedge clk);
      bus.in0 = 32'h40400000;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async rst out0", bus.out0, 32'h0);
      check("async rst out1", 32'(bus.out1), 32'h0);
      check("async rst done", 32'(bus.done), 32'h0);
      repeat (3) @(negedge clk);
      check("held rst done", 32'(bus.done), 32'h0);
      bus.running = 1'b0;
      rst = 1'b1;
      repeat (6) @(negedge clk);
      check("post rst idle done", 32'(bus.done), 32'h0);
      check("post rst idle out0", bus.out0, 32'h0);
      run_vec(200, vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
